// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
//
// Round-robin arbiter for N_REQ requesters. A winner keeps the grant while it
// keeps requesting, optionally limited to MAX_HOLD cycles. Every release is
// followed by at least one idle cycle, and arbitration restarts just past the
// last winner.
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_i       - asynchronous active-high reset
//   req_i       - level-sensitive request vector, bit k = requester k
//   gnt_o       - registered one-hot grant, zero when idle
//   gnt_idx_o   - registered binary index of the grant, zero when idle
//   gnt_valid_o - high while a grant is active (== |gnt_o)
//   hold_cnt_o  - cycles the current grant has been held, 0 in its first cycle

module rr_grant_arbiter #(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned N_REQ    = 16,
    parameter int unsigned HOLD_W   = 16,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_REQ-1:0]  req_i,
    output logic [N_REQ-1:0]  gnt_o,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic              gnt_valid_o,
    output logic [HOLD_W-1:0] hold_cnt_o
);

    // Elaboration-time parameter checks; the tool stops on these errors.
    if (N_REQ != (32'd1 << IDX_W)) begin : g_bad_n_req
        $error("rr_grant_arbiter: N_REQ=%0d must equal 2**IDX_W=%0d", N_REQ, 32'd1 << IDX_W);
    end
    if (64'(MAX_HOLD) >= (64'd1 << HOLD_W)) begin : g_bad_max_hold
        $error("rr_grant_arbiter: MAX_HOLD=%0d does not fit in HOLD_W=%0d bits",
               MAX_HOLD, HOLD_W);
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [HOLD_W-1:0]  cnt_q, cnt_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   scan;
    logic               release_grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        found   = 1'b0;
        win     = '0;
        scan    = '0;

        // Scan from ptr upwards; IDX_W-bit addition gives the modulo-N_REQ wrap
        // because N_REQ is a power of two.
        for (int i = 0; i < int'(N_REQ); i++) begin
            scan = ptr_q + IDX_W'(i);
            if (!found && req_i[scan]) begin
                found = 1'b1;
                win   = scan;
            end
        end

        release_grant = !req_i[idx_q] ||
                        ((MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD - 1)));

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d    = StGrant;
                    idx_d      = win;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    cnt_d      = '0;
                end
            end
            StGrant: begin
                if (release_grant) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = (state_q == StGrant);
    assign hold_cnt_o  = cnt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter. Two instances share stimulus:
//   dut0: unlimited hold, 3-bit hold counter (saturates at 7)
//   dut1: MAX_HOLD=4, 16-bit hold counter
// A per-instance behavioural model is compared every negedge; directed
// literal expectations pin the model to hand-worked scenarios.

module tb_rr_grant_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;

    logic [15:0] gnt0, gnt1;
    logic [3:0]  idx0, idx1;
    logic        val0, val1;
    logic [2:0]  cnt0;
    logic [15:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter #(
        .IDX_W(4), .N_REQ(16), .HOLD_W(3), .MAX_HOLD(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .gnt_o(gnt0), .gnt_idx_o(idx0), .gnt_valid_o(val0), .hold_cnt_o(cnt0)
    );

    rr_grant_arbiter #(
        .IDX_W(4), .N_REQ(16), .HOLD_W(16), .MAX_HOLD(4)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .gnt_o(gnt1), .gnt_idx_o(idx1), .gnt_valid_o(val1), .hold_cnt_o(cnt1)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int busy;
        int idx;
        int ptr;
        int cnt;
    } mstate_t;

    mstate_t m0, m1;

    function automatic mstate_t mnext(mstate_t s, logic [15:0] r, int mh, int sat);
        mstate_t n;
        int      j;
        n = s;
        if (s.busy == 0) begin
            for (int k = 0; k < 16; k++) begin
                j = (s.ptr + k) % 16;
                if (r[j] && n.busy == 0) begin
                    n.busy = 1;
                    n.idx  = j;
                    n.cnt  = 0;
                end
            end
        end else if (!r[s.idx] || (mh != 0 && s.cnt == mh - 1)) begin
            n.busy = 0;
            n.idx  = 0;
            n.cnt  = 0;
            n.ptr  = (s.idx + 1) % 16;
        end else if (s.cnt < sat) begin
            n.cnt = s.cnt + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= mnext(m0, req, 0, 7);
            m1 <= mnext(m1, req, 4, 65535);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag, input mstate_t m, input logic [15:0] g,
                             input logic [3:0] gi, input logic gv, input int hc);
        logic [15:0] eg;
        int          ei;
        eg = '0;
        ei = 0;
        if (m.busy != 0) begin
            ei = m.idx;
            eg = 16'(1) << m.idx;
        end
        chk({tag, " gnt"}, int'(g), int'(eg));
        chk({tag, " idx"}, int'(gi), ei);
        chk({tag, " valid"}, int'(gv), m.busy);
        chk({tag, " cnt"}, hc, m.cnt);
        chk({tag, " onehot"}, int'($countones(g) <= 1), 1);
    endtask

    always @(negedge clk) begin
        cmp_model("model0", m0, gnt0, idx0, val0, int'(cnt0));
        cmp_model("model1", m1, gnt1, idx1, val1, int'(cnt1));
    end

    // Literal expectation on one instance; v=0 means idle (outputs all zero).
    task automatic lit(input int which, input string tag, input int v, input int idx,
                       input int cnt);
        logic [15:0] g;
        int          eg;
        eg = (v != 0) ? (1 << idx) : 0;
        g  = (which == 0) ? gnt0 : gnt1;
        chk({tag, " gnt"}, int'(g), eg);
        chk({tag, " idx"}, (which == 0) ? int'(idx0) : int'(idx1), (v != 0) ? idx : 0);
        chk({tag, " valid"}, (which == 0) ? int'(val0) : int'(val1), v);
        chk({tag, " cnt"}, (which == 0) ? int'(cnt0) : int'(cnt1), (v != 0) ? cnt : 0);
    endtask

    // Apply a request vector for one clock; returns after the next negedge.
    task automatic step(input logic [15:0] v);
        req = v;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int ti[11] = '{3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 3};
    int tv[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    int tc[11] = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0};

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        lit(0, "reset0", 0, 0, 0);
        lit(1, "reset1", 0, 0, 0);
        rst = 1'b0;

        // Single request, release, re-grant, then async reset mid-grant
        step(16'h0020); lit(0, "single grant", 1, 5, 0);
        step(16'h0020); lit(0, "single hold", 1, 5, 1);
        step(16'h0000); lit(0, "single release", 0, 0, 0);
        step(16'h0020); lit(0, "regrant", 1, 5, 0);
        step(16'h0020); lit(1, "regrant hold", 1, 5, 1);
        #3 rst = 1'b1;
        #1 lit(0, "async reset0", 0, 0, 0);
        lit(1, "async reset1", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        // ptr was 6 before reset; from 0 the winner of {5,6} is 5
        step(16'h0060); lit(0, "ptr after reset", 1, 5, 0);
        step(16'h0000); lit(0, "release after reset", 0, 0, 0);

        // Round-robin fairness from ptr 0
        pulse_reset();
        for (int k = 0; k <= 16; k++) begin
            step(16'hFFFF);
            lit(0, $sformatf("rr%0d first", k), 1, k % 16, 0);
            step(16'hFFFF);
            lit(1, $sformatf("rr%0d second", k), 1, k % 16, 1);
            step(16'hFFFF & ~(16'(1) << (k % 16)));
            lit(0, $sformatf("rr%0d gap", k), 0, 0, 0);
        end

        // Wrap-around (ptr is 1 here)
        step(16'h4000); lit(0, "grant14", 1, 14, 0);
        step(16'h0000); lit(0, "release14", 0, 0, 0);
        step(16'h8001); lit(0, "wrap15", 1, 15, 0);
        step(16'h8001); lit(0, "wrap15 hold", 1, 15, 1);
        step(16'h0001); lit(0, "release15", 0, 0, 0);
        step(16'h8001); lit(0, "wrap0", 1, 0, 0);
        step(16'h0000); lit(0, "release0", 0, 0, 0);

        // Lock on 2 while others request (ptr is 1)
        step(16'h0004); lit(0, "lock grant2", 1, 2, 0);
        step(16'h0006); lit(0, "lock hold a", 1, 2, 1);
        step(16'h0006); lit(1, "lock hold b", 1, 2, 2);
        step(16'h0002); lit(0, "lock release", 0, 0, 0);
        step(16'h0002); lit(0, "lock wrap to 1", 1, 1, 0);
        step(16'h0000); lit(0, "lock done", 0, 0, 0);

        // Timeout on dut1 (ptr is 2); dut0 keeps 3 and saturates its counter
        for (int s = 0; s < 11; s++) begin
            step(16'h0009);
            lit(1, $sformatf("timeout step%0d", s), tv[s], ti[s], tc[s]);
        end
        lit(0, "unlimited sat", 1, 3, 7);
        step(16'h0009); lit(0, "unlimited sat hold", 1, 3, 7);
        step(16'h0000); lit(0, "final release", 0, 0, 0);
        step(16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
